// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable MIPS32 instruction memory.
package imem_pkg;
    localparam int DATA_W = 32;
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IMEM_IDLE,
        IMEM_LOAD,
        IMEM_RUN
    } imem_state_t;
endpackage

// File: rtl/imem_array.sv
// DEPTH x WIDTH synchronous RAM: one write port, one registered read port.
module imem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    // No reset on the storage: contents must survive a reset pulse.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: loader FSM, 1-cycle registered fetch with hold.
// Define IMEM_PARITY_EN to store an even-parity bit per word and fault on mismatch.
module instr_mem_loadable #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = imem_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              LoadStart,
    input  logic              LoadValid,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              LoadLast,
    output logic              Loading,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic              FetchReady,
    input  logic              FetchHold,
    output logic              FetchValid,
    output logic [DATA_W-1:0] Instruction,
    output logic              FetchFault
);
    import imem_pkg::*;

    localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    imem_state_t       state_q, state_d;
    logic [AW-1:0]     wr_ptr_q;
    logic              valid_q, fault_q;
    logic              mem_we, accept, addr_fault, rd_err;
    logic [MW-1:0]     mem_wdata, mem_rdata;

    assign addr_fault = (FetchAddr[1:0] != 2'b00) ||
                        ((FetchAddr >> 2) >= ADDR_W'(DEPTH));
    assign accept     = FetchReq && FetchReady;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IMEM_IDLE;
        else          state_q <= state_d;
    end

    // LoadStart wins over LoadValid: a restart never writes the old pointer.
    always_comb begin
        state_d    = state_q;
        Loading    = 1'b0;
        FetchReady = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IMEM_IDLE: if (LoadStart) state_d = IMEM_LOAD;
            IMEM_LOAD: begin
                Loading = 1'b1;
                if (LoadStart) begin
                    state_d = IMEM_LOAD;
                end else if (LoadValid) begin
                    mem_we = 1'b1;
                    if (LoadLast || wr_ptr_q == AW'(DEPTH - 1)) state_d = IMEM_RUN;
                end
            end
            IMEM_RUN: begin
                FetchReady = !(valid_q && FetchHold);
                if (LoadStart) state_d = IMEM_LOAD;
            end
            default: state_d = IMEM_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)       wr_ptr_q <= '0;
        else if (LoadStart) wr_ptr_q <= '0;
        else if (mem_we)    wr_ptr_q <= wr_ptr_q + 1'b1;
    end

    // A reload drops whatever fetch is in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (LoadStart || state_q != IMEM_RUN) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            fault_q <= addr_fault;
        end else if (!(valid_q && FetchHold)) begin
            valid_q <= 1'b0;
        end
    end

`ifdef IMEM_PARITY_EN
    assign mem_wdata = {^LoadData, LoadData};
    assign rd_err    = ^mem_rdata;
`else
    assign mem_wdata = LoadData;
    assign rd_err    = 1'b0;
`endif

    imem_array #(.DEPTH(DEPTH), .WIDTH(MW), .AW(AW)) u_array (
        .clk   (Clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata),
        .re    (accept),
        .raddr (FetchAddr[AW+1:2]),
        .rdata (mem_rdata)
    );

    assign FetchValid  = valid_q;
    assign FetchFault  = valid_q && (fault_q || rd_err);
    assign Instruction = (valid_q && !fault_q && !rd_err) ? mem_rdata[DATA_W-1:0]
                                                          : DATA_W'(MIPS_NOP);
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable; drives and samples on the falling edge.
module tb_instr_mem_loadable;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              LoadStart = 1'b0, LoadValid = 1'b0, LoadLast = 1'b0;
    logic [DATA_W-1:0] LoadData = '0;
    logic              Loading, FetchReady, FetchValid, FetchFault;
    logic              FetchReq = 1'b0, FetchHold = 1'b0;
    logic [ADDR_W-1:0] FetchAddr = '0;
    logic [DATA_W-1:0] Instruction;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    instr_mem_loadable #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData),
        .LoadLast(LoadLast), .Loading(Loading),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchReady(FetchReady),
        .FetchHold(FetchHold), .FetchValid(FetchValid),
        .Instruction(Instruction), .FetchFault(FetchFault)
    );

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (FetchReady !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", FetchReady); end
        checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", FetchValid); end
        checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", Instruction); end
        checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", FetchFault); end
        checks++; if (Loading !== 1'b0) begin errors++; $display("FAIL reset_loading got=%b exp=0", Loading); end
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++; if (FetchReady !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", FetchReady); end
    endtask

    // Fill every word without LoadLast: the write at DEPTH-1 must end the load.
    task automatic test_full_load();
        LoadStart = 1'b1;
        @(negedge Clk);
        LoadStart = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                checks++; if (Loading !== 1'b1) begin errors++; $display("FAIL full_loading_before_last got=%b exp=1", Loading); end
            end
            LoadValid = 1'b1; LoadData = 32'h1000_0000 + i; LoadLast = 1'b0;
            @(negedge Clk);
        end
        LoadValid = 1'b0;
        checks++; if (Loading !== 1'b0) begin errors++; $display("FAIL full_loading_after got=%b exp=0", Loading); end
        checks++; if (FetchReady !== 1'b1) begin errors++; $display("FAIL full_ready got=%b exp=1", FetchReady); end
        FetchReq = 1'b1; FetchAddr = 32'h3FC;
        @(negedge Clk);
        FetchReq = 1'b0;
        checks++; if (Instruction !== 32'h1000_00FF) begin errors++; $display("FAIL full_last_word got=%h exp=100000ff", Instruction); end
        checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL full_last_fault got=%b exp=0", FetchFault); end
        @(negedge Clk);
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        words[0] = 32'h3408_0032; words[1] = 32'hac08_0000; words[2] = 32'h3408_0028;
        LoadStart = 1'b1;
        @(negedge Clk);
        LoadStart = 1'b0;
        checks++; if (Loading !== 1'b1) begin errors++; $display("FAIL load_loading_rise got=%b exp=1", Loading); end
        checks++; if (FetchReady !== 1'b0) begin errors++; $display("FAIL load_ready got=%b exp=0", FetchReady); end
        for (int i = 0; i < 3; i++) begin
            LoadValid = 1'b1; LoadData = words[i]; LoadLast = (i == 2);
            @(negedge Clk);
        end
        LoadValid = 1'b0; LoadLast = 1'b0;
        checks++; if (Loading !== 1'b0) begin errors++; $display("FAIL load_loading_fall got=%b exp=0", Loading); end
        checks++; if (FetchReady !== 1'b1) begin errors++; $display("FAIL load_run_ready got=%b exp=1", FetchReady); end
    endtask

    task automatic test_fetch();
        FetchReq = 1'b1; FetchAddr = 32'h04;
        @(negedge Clk);
        FetchReq = 1'b0;
        checks++; if (FetchValid !== 1'b1) begin errors++; $display("FAIL fetch_valid got=%b exp=1", FetchValid); end
        checks++; if (Instruction !== 32'hac08_0000) begin errors++; $display("FAIL fetch_instr got=%h exp=ac080000", Instruction); end
        checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL fetch_fault got=%b exp=0", FetchFault); end
        @(negedge Clk);
        checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL fetch_valid_fall got=%b exp=0", FetchValid); end
    endtask

    task automatic test_back_to_back();
        FetchReq = 1'b1; FetchAddr = 32'h00;
        @(negedge Clk);
        checks++; if (Instruction !== 32'h3408_0032 || FetchValid !== 1'b1) begin errors++; $display("FAIL b2b_first got=%h/%b exp=34080032/1", Instruction, FetchValid); end
        FetchAddr = 32'h08;
        @(negedge Clk);
        FetchReq = 1'b0;
        checks++; if (Instruction !== 32'h3408_0028 || FetchValid !== 1'b1) begin errors++; $display("FAIL b2b_second got=%h/%b exp=34080028/1", Instruction, FetchValid); end
        @(negedge Clk);
    endtask

    task automatic test_fault();
        FetchReq = 1'b1; FetchAddr = 32'h06;
        @(negedge Clk);
        checks++; if (Instruction !== 32'h0 || FetchFault !== 1'b1 || FetchValid !== 1'b1) begin errors++; $display("FAIL fault_misaligned got=%h/%b/%b exp=0/1/1", Instruction, FetchFault, FetchValid); end
        FetchAddr = DEPTH * 4;
        @(negedge Clk);
        checks++; if (Instruction !== 32'h0 || FetchFault !== 1'b1) begin errors++; $display("FAIL fault_range got=%h/%b exp=0/1", Instruction, FetchFault); end
        FetchAddr = DEPTH * 4 - 4;
        @(negedge Clk);
        FetchReq = 1'b0;
        checks++; if (Instruction !== 32'h1000_00FF || FetchFault !== 1'b0) begin errors++; $display("FAIL fault_top_inrange got=%h/%b exp=100000ff/0", Instruction, FetchFault); end
        @(negedge Clk);
    endtask

    task automatic test_hold();
        FetchReq = 1'b1; FetchAddr = 32'h04;
        @(negedge Clk);
        checks++; if (Instruction !== 32'hac08_0000) begin errors++; $display("FAIL hold_first got=%h exp=ac080000", Instruction); end
        FetchHold = 1'b1; FetchAddr = 32'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++; if (Instruction !== 32'hac08_0000 || FetchValid !== 1'b1 || FetchReady !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d got=%h/%b/%b exp=ac080000/1/0", i, Instruction, FetchValid, FetchReady); end
        end
        FetchHold = 1'b0;
        @(negedge Clk);
        FetchReq = 1'b0;
        checks++; if (Instruction !== 32'h3408_0032 || FetchValid !== 1'b1) begin errors++; $display("FAIL hold_release got=%h/%b exp=34080032/1", Instruction, FetchValid); end
        @(negedge Clk);
    endtask

    // Reload with a fetch accepted on the same edge; LoadValid alongside LoadStart is dropped.
    task automatic test_reload();
        FetchReq = 1'b1; FetchAddr = 32'h04;
        LoadStart = 1'b1; LoadValid = 1'b1; LoadData = 32'hdead_beef;
        @(negedge Clk);
        LoadStart = 1'b0; LoadValid = 1'b0;
        checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL reload_valid got=%b exp=0", FetchValid); end
        checks++; if (Loading !== 1'b1) begin errors++; $display("FAIL reload_loading got=%b exp=1", Loading); end
        LoadValid = 1'b1; LoadData = 32'h1111_1111;
        @(negedge Clk);
        checks++; if (FetchReady !== 1'b0) begin errors++; $display("FAIL reload_ready_mid got=%b exp=0", FetchReady); end
        LoadData = 32'h2222_2222; LoadLast = 1'b1;
        @(negedge Clk);
        LoadValid = 1'b0; LoadLast = 1'b0;
        checks++; if (FetchReady !== 1'b1) begin errors++; $display("FAIL reload_ready_end got=%b exp=1", FetchReady); end
        @(negedge Clk);
        checks++; if (Instruction !== 32'h2222_2222) begin errors++; $display("FAIL reload_word1 got=%h exp=22222222", Instruction); end
        FetchAddr = 32'h00;
        @(negedge Clk);
        checks++; if (Instruction !== 32'h1111_1111) begin errors++; $display("FAIL reload_word0 got=%h exp=11111111", Instruction); end
        FetchAddr = 32'h08;
        @(negedge Clk);
        FetchReq = 1'b0;
        checks++; if (Instruction !== 32'h3408_0028) begin errors++; $display("FAIL reload_kept got=%h exp=34080028", Instruction); end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_load();
        LoadStart = 1'b1;
        @(negedge Clk);
        LoadStart = 1'b0; LoadValid = 1'b1; LoadData = 32'h5555_5555;
        @(negedge Clk);
        LoadValid = 1'b0;
        Reset_n = 1'b0;
        #1;
        checks++; if (Loading !== 1'b0) begin errors++; $display("FAIL rst_mid_loading got=%b exp=0", Loading); end
        @(negedge Clk);
        Reset_n = 1'b1;
        LoadStart = 1'b1;
        @(negedge Clk);
        LoadStart = 1'b0; LoadValid = 1'b1; LoadLast = 1'b1; LoadData = 32'h3333_3333;
        @(negedge Clk);
        LoadValid = 1'b0; LoadLast = 1'b0;
        FetchReq = 1'b1; FetchAddr = 32'h04;
        @(negedge Clk);
        checks++; if (Instruction !== 32'h2222_2222) begin errors++; $display("FAIL rst_mid_retained got=%h exp=22222222", Instruction); end
        FetchAddr = 32'h00;
        @(negedge Clk);
        FetchReq = 1'b0;
        checks++; if (Instruction !== 32'h3333_3333) begin errors++; $display("FAIL rst_mid_word0 got=%h exp=33333333", Instruction); end
        @(negedge Clk);
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        dut.u_array.mem[1][0] = ~dut.u_array.mem[1][0];
        FetchReq = 1'b1; FetchAddr = 32'h04;
        @(negedge Clk);
        FetchReq = 1'b0;
        checks++; if (FetchFault !== 1'b1 || Instruction !== 32'h0) begin errors++; $display("FAIL parity got=%b/%h exp=1/0", FetchFault, Instruction); end
        @(negedge Clk);
    endtask
`endif

    initial begin
        @(negedge Clk);
        test_reset();
        test_full_load();
        test_load();
        test_fetch();
        test_back_to_back();
        test_fault();
        test_hold();
        test_reload();
        test_reset_mid_load();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
